// File: rtl/parser_pkg.sv
// Shared types and helpers for the parser/deparser header-type lookup.
// Holds the rule and result layouts plus a lowest-set-bit index helper.
package parser_pkg;

    localparam int PKG_TYPE_BITS = 32;
    localparam int LSB_NONE      = 64;

    typedef struct packed {
        logic [7:0]  hdr_id;
        logic [7:0]  hdr_len;
        logic [15:0] next_type;
        logic [31:0] flags;
    } lookup_rst_t;

    typedef struct packed {
        logic                     valid;
        logic [PKG_TYPE_BITS-1:0] mask;
        logic [PKG_TYPE_BITS-1:0] data;
        lookup_rst_t              result;
    } type_rule_v2_t;

    function automatic int lsb_index(input logic [63:0] vec);
        int idx;
        idx = LSB_NONE;
        for (int i = 63; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-index-wins priority encoder: one-hot grant, binary index, any-hit.
// The index reads WIDTH when nothing is requested.
module prio_enc_lsb
    import parser_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [63:0] req_ext;

    always_comb begin
        req_ext = '0;
        req_ext[WIDTH-1:0] = req;
    end

    assign any    = |req;
    assign onehot = req & (~req + WIDTH'(1));
    assign idx    = any ? IDX_W'(lsb_index(req_ext)) : IDX_W'(WIDTH);

endmodule

// File: rtl/lookup_type_prio.sv
// Masked header-type lookup with priority select, elastic output pipeline
// and saturating per-rule / miss hit counters.
module lookup_type_prio
    import parser_pkg::*;
#(
    parameter int RULE_NUM     = 16,
    parameter int TYPE_NUM     = 2,
    parameter int TYPE_WIDTH   = 16,
    parameter int RESULT_WIDTH = 64,
    parameter int PIPE_STAGES  = 1,
    parameter int CNT_WIDTH    = 32,
    parameter int IDX_W        = $clog2(RULE_NUM + 1)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [TYPE_NUM*TYPE_WIDTH-1:0] i_type,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic                           o_hit,
    output logic [IDX_W-1:0]               o_rule_idx,
    output logic [RESULT_WIDTH-1:0]        o_result,
    input  logic                           i_cfg_wren,
    input  logic [IDX_W-1:0]               i_cfg_addr,
    input  logic                           i_cfg_rule_v,
    input  logic [TYPE_NUM*TYPE_WIDTH-1:0] i_cfg_mask,
    input  logic [TYPE_NUM*TYPE_WIDTH-1:0] i_cfg_data,
    input  logic [RESULT_WIDTH-1:0]        i_cfg_result,
    input  logic                           i_def_wren,
    input  logic                           i_cnt_clr,
    input  logic [IDX_W-1:0]               i_cnt_addr,
    output logic [CNT_WIDTH-1:0]           o_cnt_data
);

    localparam int KW = TYPE_NUM * TYPE_WIDTH;
    localparam int DW = 1 + IDX_W + RESULT_WIDTH;

    logic [RULE_NUM-1:0]     rule_v;
    logic [KW-1:0]           rule_mask [RULE_NUM];
    logic [KW-1:0]           rule_data [RULE_NUM];
    logic [RESULT_WIDTH-1:0] rule_res  [RULE_NUM];
    logic [RESULT_WIDTH-1:0] def_res;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rule_v  <= '0;
            def_res <= '0;
            for (int i = 0; i < RULE_NUM; i++) begin
                rule_mask[i] <= '0;
                rule_data[i] <= '0;
                rule_res[i]  <= '0;
            end
        end else begin
            if (i_def_wren) def_res <= i_cfg_result;
            for (int i = 0; i < RULE_NUM; i++) begin
                if (i_cfg_wren && i_cfg_addr == IDX_W'(i)) begin
                    rule_v[i]    <= i_cfg_rule_v;
                    rule_mask[i] <= i_cfg_mask;
                    // Pre-masked so stray data bits never block a match
                    rule_data[i] <= i_cfg_data & i_cfg_mask;
                    rule_res[i]  <= i_cfg_result;
                end
            end
        end
    end

    logic [RULE_NUM-1:0]     hit_vec;
    logic [RULE_NUM-1:0]     hit_oh;
    logic [IDX_W-1:0]        s0_idx;
    logic                    s0_hit;
    logic [RESULT_WIDTH-1:0] s0_res;
    logic [DW-1:0]           s0_d;

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < RULE_NUM; i++) begin
            hit_vec[i] = rule_v[i] &&
                         ((rule_mask[i] & i_type) == rule_data[i]);
        end
    end

    prio_enc_lsb #(
        .WIDTH (RULE_NUM),
        .IDX_W (IDX_W)
    ) u_enc (
        .req    (hit_vec),
        .onehot (hit_oh),
        .idx    (s0_idx),
        .any    (s0_hit)
    );

    always_comb begin
        s0_res = '0;
        for (int i = 0; i < RULE_NUM; i++) begin
            s0_res = s0_res | ({RESULT_WIDTH{hit_oh[i]}} & rule_res[i]);
        end
        if (!s0_hit) s0_res = def_res;
    end

    assign s0_d = {s0_hit, s0_idx, s0_res};

    logic [DW-1:0] out_d;

    generate
        if (PIPE_STAGES == 0) begin : g_comb
            assign o_valid = i_valid;
            assign o_ready = i_ready;
            assign out_d   = s0_d;
        end else begin : g_pipe
            logic [PIPE_STAGES-1:0] st_v;
            logic [PIPE_STAGES-1:0] st_ld;
            logic [PIPE_STAGES-1:0] in_v;
            logic [DW-1:0]          st_d [PIPE_STAGES];
            logic [DW-1:0]          in_d [PIPE_STAGES];
            logic                   chain;

            // A stage loads if it or any later stage is empty, or the sink takes
            always_comb begin
                chain = i_ready;
                st_ld = '0;
                for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
                    chain    = chain | !st_v[s];
                    st_ld[s] = chain;
                end
            end

            always_comb begin
                in_v    = '0;
                in_v[0] = i_valid;
                for (int s = 0; s < PIPE_STAGES; s++) in_d[s] = s0_d;
                for (int s = 1; s < PIPE_STAGES; s++) begin
                    in_v[s] = st_v[s-1];
                    in_d[s] = st_d[s-1];
                end
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    st_v <= '0;
                    for (int s = 0; s < PIPE_STAGES; s++) st_d[s] <= '0;
                end else begin
                    for (int s = 0; s < PIPE_STAGES; s++) begin
                        if (st_ld[s]) begin
                            st_v[s] <= in_v[s];
                            st_d[s] <= in_d[s];
                        end
                    end
                end
            end

            assign o_ready = st_ld[0];
            assign o_valid = st_v[PIPE_STAGES-1];
            assign out_d   = st_d[PIPE_STAGES-1];
        end
    endgenerate

    assign {o_hit, o_rule_idx, o_result} = out_d;

    logic                 accept;
    logic [CNT_WIDTH-1:0] cnt [RULE_NUM+1];
    logic [CNT_WIDTH-1:0] cnt_sel;

    assign accept = i_valid & o_ready;

    always_comb begin
        cnt_sel = '0;
        for (int i = 0; i <= RULE_NUM; i++) begin
            if (i_cnt_addr == IDX_W'(i)) cnt_sel = cnt[i];
        end
    end

    // Entry RULE_NUM is the miss counter, matching the miss index
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cnt_data <= '0;
            for (int i = 0; i <= RULE_NUM; i++) cnt[i] <= '0;
        end else begin
            o_cnt_data <= cnt_sel;
            for (int i = 0; i <= RULE_NUM; i++) begin
                if (i_cnt_clr) begin
                    cnt[i] <= '0;
                end else if (accept && s0_idx == IDX_W'(i) &&
                             cnt[i] != '1) begin
                    cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lookup_type_prio.sv
// Scoreboard bench for lookup_type_prio: two-stage pipeline, 4-bit counters.
// Expected results come from a reference rule table kept by the bench.
module tb_lookup_type_prio;
    import parser_pkg::*;

    localparam int RN = 16;
    localparam int TN = 2;
    localparam int TW = 16;
    localparam int RW = 64;
    localparam int PS = 2;
    localparam int CW = 4;
    localparam int IW = 5;
    localparam int KW = TN * TW;
    localparam int EW = 1 + IW + RW;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [KW-1:0] i_type = '0;
    logic          o_valid;
    logic          i_ready = 1'b1;
    logic          o_hit;
    logic [IW-1:0] o_rule_idx;
    logic [RW-1:0] o_result;
    logic          i_cfg_wren = 1'b0;
    logic [IW-1:0] i_cfg_addr = '0;
    logic          i_cfg_rule_v = 1'b0;
    logic [KW-1:0] i_cfg_mask = '0;
    logic [KW-1:0] i_cfg_data = '0;
    logic [RW-1:0] i_cfg_result = '0;
    logic          i_def_wren = 1'b0;
    logic          i_cnt_clr = 1'b0;
    logic [IW-1:0] i_cnt_addr = '0;
    logic [CW-1:0] o_cnt_data;

    always #5 clk = ~clk;

    lookup_type_prio #(
        .RULE_NUM     (RN),
        .TYPE_NUM     (TN),
        .TYPE_WIDTH   (TW),
        .RESULT_WIDTH (RW),
        .PIPE_STAGES  (PS),
        .CNT_WIDTH    (CW),
        .IDX_W        (IW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_type       (i_type),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_hit        (o_hit),
        .o_rule_idx   (o_rule_idx),
        .o_result     (o_result),
        .i_cfg_wren   (i_cfg_wren),
        .i_cfg_addr   (i_cfg_addr),
        .i_cfg_rule_v (i_cfg_rule_v),
        .i_cfg_mask   (i_cfg_mask),
        .i_cfg_data   (i_cfg_data),
        .i_cfg_result (i_cfg_result),
        .i_def_wren   (i_def_wren),
        .i_cnt_clr    (i_cnt_clr),
        .i_cnt_addr   (i_cnt_addr),
        .o_cnt_data   (o_cnt_data)
    );

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int first_acc = -1;
    int first_out = -1;
    int stall_left = 0;
    logic acc_last = 1'b0;

    logic [EW-1:0] sb [$];
    logic          m_v    [RN];
    logic [KW-1:0] m_mask [RN];
    logic [KW-1:0] m_data [RN];
    logic [RW-1:0] m_res  [RN];
    logic [RW-1:0] m_def;
    int            m_cnt  [RN+1];

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] mk_res(input logic [7:0] id);
        lookup_rst_t r;
        r.hdr_id    = id;
        r.hdr_len   = id + 8'd20;
        r.next_type = {id, 8'h5A};
        r.flags     = {4{id}};
        return r;
    endfunction

    function automatic logic [EW-1:0] exp_lookup(input logic [KW-1:0] t);
        for (int i = 0; i < RN; i++) begin
            if (m_v[i] && ((t & m_mask[i]) == m_data[i]))
                return {1'b1, IW'(i), m_res[i]};
        end
        return {1'b0, IW'(RN), m_def};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RN; i++) begin
            m_v[i] = 1'b0;
            m_mask[i] = '0;
            m_data[i] = '0;
            m_res[i] = '0;
        end
        for (int i = 0; i <= RN; i++) m_cnt[i] = 0;
        m_def = '0;
    endtask

    task automatic cyc();
        logic [EW-1:0] e;
        logic [IW-1:0] win;
        int a;
        #1;
        acc_last = 1'b0;
        if (o_valid) begin
            if (first_out < 0) first_out = cycle;
            if (sb.size() == 0) begin
                chk("spurious_valid", 128'(o_valid), 128'(0));
            end else begin
                chk("out", 128'({o_hit, o_rule_idx, o_result}), 128'(sb[0]));
                if (i_ready) void'(sb.pop_front());
            end
        end
        if (i_valid && o_ready) begin
            acc_last = 1'b1;
            e = exp_lookup(i_type);
            sb.push_back(e);
            if (first_acc < 0) first_acc = cycle;
            win = e[EW-2 -: IW];
            if (!i_cnt_clr && m_cnt[win] < CMAX) m_cnt[win]++;
        end
        if (i_cnt_clr) begin
            for (int i = 0; i <= RN; i++) m_cnt[i] = 0;
        end
        if (i_def_wren) m_def = i_cfg_result;
        a = int'(i_cfg_addr);
        if (i_cfg_wren && a < RN) begin
            m_v[a]    = i_cfg_rule_v;
            m_mask[a] = i_cfg_mask;
            m_data[a] = i_cfg_data & i_cfg_mask;
            m_res[a]  = i_cfg_result;
        end
        @(posedge clk);
        @(negedge clk);
        cycle++;
        if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) i_ready = 1'b1;
        end
    endtask

    task automatic wr_rule(input int addr, input logic v,
                           input logic [KW-1:0] mask, data,
                           input logic [RW-1:0] res);
        i_cfg_wren   = 1'b1;
        i_cfg_addr   = IW'(addr);
        i_cfg_rule_v = v;
        i_cfg_mask   = mask;
        i_cfg_data   = data;
        i_cfg_result = res;
        cyc();
        i_cfg_wren   = 1'b0;
        i_def_wren   = 1'b0;
    endtask

    task automatic lookup(input logic [15:0] t0, input logic [15:0] t1);
        int n;
        n = 0;
        i_valid = 1'b1;
        i_type  = {t1, t0};
        do begin
            cyc();
            n++;
        end while (!acc_last && n < 20);
        chk("accept", 128'(acc_last), 128'(1));
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        i_valid = 1'b0;
        while (sb.size() > 0 && n < 30) begin
            cyc();
            n++;
        end
        chk("drain_empty", 128'(sb.size()), 128'(0));
    endtask

    task automatic rd_cnt(input int addr, input int exp, input string tag);
        i_cnt_addr = IW'(addr);
        cyc();
        chk(tag, 128'(o_cnt_data), 128'(exp));
    endtask

    logic [15:0] tv [6];

    initial begin
        #200000;
        $display("FAIL watchdog time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = 16'h0800; tv[1] = 16'h08AA; tv[2] = 16'h1234;
        tv[3] = 16'h4433; tv[4] = 16'h86DD; tv[5] = 16'h0801;
        model_reset();

        #1;
        chk("rst_valid", 128'(o_valid), 128'(0));
        chk("rst_hit", 128'(o_hit), 128'(0));
        chk("rst_idx", 128'(o_rule_idx), 128'(0));
        chk("rst_result", 128'(o_result), 128'(0));
        chk("rst_cnt", 128'(o_cnt_data), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc();

        wr_rule(3, 1'b1, 32'h0000_FFFF, 32'h0000_0800, mk_res(8'h03));
        wr_rule(5, 1'b1, 32'h0000_FF00, 32'h0000_08FF, mk_res(8'h05));
        wr_rule(7, 1'b1, 32'hFFFF_0000, 32'h0011_0000, mk_res(8'h07));
        i_def_wren = 1'b1;
        wr_rule(9, 1'b1, 32'h00FF_00FF, 32'h0022_0033, mk_res(8'hDE));
        wr_rule(16, 1'b1, 32'h0000_0000, 32'h0000_0000, mk_res(8'hEE));

        lookup(16'h0800, 16'h0000);
        lookup(16'h08AA, 16'h0000);
        lookup(16'h1234, 16'h0011);
        lookup(16'h0800, 16'h0011);
        lookup(16'h4433, 16'h5522);
        lookup(16'h1234, 16'h0000);
        drain();

        first_acc = -1;
        first_out = -1;
        i_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) begin
                i_ready = 1'b0;
                stall_left = 3;
            end
            lookup(tv[$urandom_range(0, 5)], (k % 3 == 0) ? 16'h0011 : 16'h5522);
        end
        drain();
        chk("latency", 128'(first_out - first_acc), 128'(2));

        i_cfg_wren   = 1'b1;
        i_cfg_addr   = IW'(3);
        i_cfg_rule_v = 1'b1;
        i_cfg_mask   = 32'h0000_FFFF;
        i_cfg_data   = 32'h0000_86DD;
        i_cfg_result = mk_res(8'h33);
        i_valid      = 1'b1;
        i_type       = 32'h0000_86DD;
        cyc();
        i_cfg_wren = 1'b0;
        lookup(16'h86DD, 16'h0000);
        lookup(16'h0800, 16'h0000);
        drain();

        i_cnt_clr = 1'b1;
        cyc();
        i_cnt_clr = 1'b0;
        for (int k = 0; k < 5; k++) lookup(16'h86DD, 16'h0000);
        lookup(16'h1234, 16'h0000);
        lookup(16'h0000, 16'h0000);
        drain();
        rd_cnt(3, 5, "cnt_rule3");
        rd_cnt(RN, 2, "cnt_miss");

        i_cnt_clr = 1'b1;
        i_valid   = 1'b1;
        i_type    = 32'h0000_86DD;
        cyc();
        i_cnt_clr = 1'b0;
        i_valid   = 1'b0;
        drain();
        rd_cnt(3, 0, "cnt_clr_wins");

        for (int k = 0; k < 20; k++) lookup(16'h86DD, 16'h0000);
        drain();
        rd_cnt(3, CMAX, "cnt_saturate");

        i_valid = 1'b1;
        i_type  = 32'h0000_86DD;
        cyc();
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("midrst_valid", 128'(o_valid), 128'(0));
        sb.delete();
        model_reset();
        i_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        cyc();
        chk("postrst_valid", 128'(o_valid), 128'(0));
        rd_cnt(3, 0, "postrst_cnt3");
        rd_cnt(RN, 0, "postrst_miss");

        lookup(16'h0800, 16'h0000);
        i_def_wren   = 1'b1;
        i_cfg_result = mk_res(8'hD5);
        cyc();
        i_def_wren = 1'b0;
        lookup(16'h0800, 16'h0000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lookup_type_prio.md
Name:
lookup_type_prio

Overview:
- Parametrised next-generation header-type lookup for the parser/deparser stages.
- Matches TYPE_NUM masked type fields against RULE_NUM rules and selects the lowest-index hit with a true priority encoder (no 8-rule limit).
- Returns the winning rule's packed result, or a programmable default on miss, through a valid/ready elastic pipeline of configurable depth.
- Adds per-rule and miss hit counters with a readback port.

Parameters:
- RULE_NUM, 16: number of rules, 1..64.
- TYPE_NUM, 2: number of type fields per lookup.
- TYPE_WIDTH, 16: bits per type field.
- RESULT_WIDTH, 64: packed lookup_rst_t payload width.
- PIPE_STAGES, 1: registered output stages, 0..2.
- CNT_WIDTH, 32: hit counter width.
- IDX_W, $clog2(RULE_NUM+1): rule index and counter address width (derived).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_valid  in  1  lookup request valid.
- o_ready  out  1  lookup request accepted when high with i_valid.
- i_type  in  TYPE_NUM*TYPE_WIDTH  packed type fields; field j at [j*TYPE_WIDTH +: TYPE_WIDTH].
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_hit  out  1  a rule matched.
- o_rule_idx  out  IDX_W  winning rule index; RULE_NUM on miss.
- o_result  out  RESULT_WIDTH  winning rule result, or the default result on miss.
- i_cfg_wren  in  1  rule write strobe.
- i_cfg_addr  in  IDX_W  rule index to write; values >= RULE_NUM are ignored.
- i_cfg_rule_v  in  1  rule valid bit.
- i_cfg_mask  in  TYPE_NUM*TYPE_WIDTH  rule mask.
- i_cfg_data  in  TYPE_NUM*TYPE_WIDTH  rule compare data.
- i_cfg_result  in  RESULT_WIDTH  rule result.
- i_def_wren  in  1  write i_cfg_result as the default (miss) result.
- i_cnt_clr  in  1  clear all counters.
- i_cnt_addr  in  IDX_W  counter select; RULE_NUM selects the miss counter.
- o_cnt_data  out  CNT_WIDTH  selected counter, registered, 1-cycle latency.

Behaviour:
- Reset (async, i_rst=1):
  - All rule valid bits, the default result and all counters go to 0.
  - Every pipeline stage is empty.
  - o_valid=0, o_hit=0, o_rule_idx=0, o_result=0, o_cnt_data=0.
- Rule write stores data as i_cfg_data & i_cfg_mask, so unmasked data bits can never block a match.
- Match: rule i hits when valid_i is 1 and (mask_i & type) == data_i for every field j.
- Priority: the lowest hitting index wins. With no hit, o_hit=0, o_rule_idx=RULE_NUM and o_result is the default.
- Config timing:
  - A write at edge N affects lookups accepted after edge N.
  - Writes to the same rule in consecutive cycles take the last value.
  - Both wren strobes may be active in the same cycle; each acts independently.
- PIPE_STAGES=0: fully combinational; o_valid=i_valid, o_ready=i_ready.
- PIPE_STAGES=k>0:
  - Chain of k registered stages. Each stage loads when it is empty or its output is consumed.
  - o_ready = !stage0_valid | stage0_advance; stage0 is combinational, with no i_ready-to-o_ready dependency beyond that.
  - Latency is k cycles under no back-pressure; throughput is 1 lookup per cycle.
  - Held outputs are stable while o_valid=1 and i_ready=0.
- Counters:
  - The winning rule's counter (or the miss counter) increments on each accepted request (i_valid & o_ready).
  - Counters saturate at all-ones.
  - i_cnt_clr in the same cycle as an increment: clear wins and the counter becomes 0.
  - o_cnt_data reflects counter values before the current edge's update.
- Reset mid-traffic: in-flight results are discarded and no o_valid pulse is produced.

Decomposition:
- Shared package (parser_pkg) holds:
  - the type_rule_v2_t struct {valid, mask, data, result};
  - the RESULT_WIDTH-compatible lookup_rst_t;
  - a function for the lowest-set-bit index.
- Sub-module prio_enc_lsb(WIDTH): one-hot plus binary index plus any-hit output; reusable by the deparser.

Test Plan:
- Rule 3 mask 0xFFFF/data 0x0800 on field0, rule 5 mask 0xFF00/data 0x0800; type0=0x0800 -> o_hit=1, o_rule_idx=3, rule 3 result.
- Type0=0x08AA with the rule 3 and rule 5 config above -> rule 5 wins; all rules invalid -> o_hit=0, o_rule_idx=RULE_NUM, default result.
- PIPE_STAGES=2, 10 back-to-back lookups, i_ready low for 3 cycles mid-burst -> in-order results, none lost or duplicated, outputs stable while stalled, first result 2 cycles after the first acceptance.
- Rewrite rule 3 in cycle N, lookup accepted at N+1 -> new rule applied; lookup accepted at N -> old rule applied.
- 5 hits on rule 3 and 2 misses, then i_cnt_addr=3 and i_cnt_addr=RULE_NUM -> read 5 and 2; i_cnt_clr with a simultaneous hit -> 0.
- CNT_WIDTH=4, 20 hits -> counter saturates at 0xF; assert i_rst during a burst -> o_valid drops immediately and counters read 0.
